// File: rtl/addertree_pkg.sv
// Shared definitions for the adder-tree block family: scheduler state encoding,
// default widths and the width helper also used by the tree itself.
package addertree_pkg;

  localparam int IWIDTH_DEF  = 8;
  localparam int OWIDTH_DEF  = 16;
  localparam int NINPUTS_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT,
    RESP
  } state_e;

  // Bits needed to hold the values 0 .. value-1, never less than one bit.
  function automatic int CLogB2(input int value);
    int bits;
    bits = 1;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

endpackage

// File: rtl/addertree_arbiter_rr.sv
// Combinational round-robin pick: first asserted request at or after ptr_i,
// wrapping modulo NREQ.
module rr_arbiter #(
  parameter int NREQ = 4,
  localparam int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [IDW-1:0]  grant_o,
  output logic            any_o
);

  logic [IDW:0]   sum;
  logic [IDW-1:0] idx;

  // Scan from the farthest offset down so the nearest requester overwrites last.
  always_comb begin
    grant_o = '0;
    any_o   = 1'b0;
    sum     = '0;
    idx     = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      sum = {1'b0, ptr_i} + (IDW + 1)'(i);
      if (sum >= (IDW + 1)'(NREQ)) sum = sum - (IDW + 1)'(NREQ);
      idx = sum[IDW-1:0];
      if (req_i[idx]) begin
        grant_o = idx;
        any_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/addertree_arbiter.sv
// Round-robin scheduler sharing one pipelined adder tree among NREQ requesters,
// with a registered valid/ready response port and a sticky completion watchdog.
module addertree_arbiter
  import addertree_pkg::*;
#(
  parameter int NREQ    = NINPUTS_DEF,
  parameter int OWIDTH  = OWIDTH_DEF,
  parameter int TIMEOUT = 64,
  localparam int IDW    = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ack,
  output logic [IDW-1:0]    tree_sel,
  output logic              tree_go,
  input  logic              tree_ready,
  input  logic [OWIDTH-1:0] tree_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [OWIDTH-1:0] rsp_data,
  output logic              busy,
  output logic              err_timeout
);

  localparam int CW = CLogB2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]    grant_id_q, grant_id_d;
  logic [IDW-1:0]    tree_sel_q, tree_sel_d;
  logic [IDW-1:0]    rsp_id_q, rsp_id_d;
  logic [OWIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [NREQ-1:0]   req_ack_q, req_ack_d;
  logic [CW-1:0]     wdog_q, wdog_d;
  logic              tree_go_q, tree_go_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              err_q, err_d;

  logic [IDW-1:0]    pick;
  logic              pick_valid;
  logic [CW-1:0]     wdog_inc;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .grant_o (pick),
    .any_o   (pick_valid)
  );

  assign wdog_inc = wdog_q + CW'(1);

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    tree_sel_d  = tree_sel_q;
    rsp_id_d    = rsp_id_q;
    rsp_data_d  = rsp_data_q;
    req_ack_d   = '0;
    wdog_d      = wdog_q;
    tree_go_d   = 1'b0;
    rsp_valid_d = rsp_valid_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_id_d = pick;
          tree_sel_d = pick;
          tree_go_d  = 1'b1;
          state_d    = LAUNCH;
        end
      end
      LAUNCH: begin
        wdog_d  = '0;
        state_d = WAIT;
      end
      // A real completion wins over a watchdog expiry in the same cycle.
      WAIT: begin
        wdog_d = wdog_inc;
        if (tree_ready) begin
          rsp_data_d  = tree_result;
          rsp_id_d    = grant_id_q;
          req_ack_d   = NREQ'(1) << grant_id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else if (wdog_inc == CW'(TIMEOUT)) begin
          err_d       = 1'b1;
          rsp_data_d  = '0;
          rsp_id_d    = grant_id_q;
          req_ack_d   = NREQ'(1) << grant_id_q;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (grant_id_q == IDW'(NREQ - 1)) ? '0 : grant_id_q + IDW'(1);
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      grant_id_q  <= '0;
      tree_sel_q  <= '0;
      rsp_id_q    <= '0;
      rsp_data_q  <= '0;
      req_ack_q   <= '0;
      wdog_q      <= '0;
      tree_go_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_id_q  <= grant_id_d;
      tree_sel_q  <= tree_sel_d;
      rsp_id_q    <= rsp_id_d;
      rsp_data_q  <= rsp_data_d;
      req_ack_q   <= req_ack_d;
      wdog_q      <= wdog_d;
      tree_go_q   <= tree_go_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
    end
  end

  assign req_ack     = req_ack_q;
  assign tree_sel    = tree_sel_q;
  assign tree_go     = tree_go_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = rsp_id_q;
  assign rsp_data    = rsp_data_q;
  assign err_timeout = err_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_addertree_arbiter.sv
// Scenario bench for addertree_arbiter: a latency-programmable tree model and a
// round-robin reference drive per-feature tasks, all sampled on the falling edge.
module tb_addertree_arbiter;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_ack;
  logic [1:0]  tree_sel;
  logic        tree_go;
  logic        tree_ready;
  logic [15:0] tree_result = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [1:0]  rsp_id;
  logic [15:0] rsp_data;
  logic        busy;
  logic        err_timeout;

  logic modelReady = 1'b0;
  logic strayReady = 1'b0;
  assign tree_ready = modelReady | strayReady;

  addertree_arbiter #(.NREQ(4), .OWIDTH(16), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ack     (req_ack),
    .tree_sel    (tree_sel),
    .tree_go     (tree_go),
    .tree_ready  (tree_ready),
    .tree_result (tree_result),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_id      (rsp_id),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  int          treeLatency = 4;
  bit          randLatency = 0;
  bit          treeNever = 0;
  int          cd = 0;
  logic [15:0] nextResult = 16'h0001;
  int          dropMode = 1;
  bit          randReady = 0;
  int          errRise = -1;
  int          expPtr = 0;

  int          goCyc[$];
  logic [1:0]  goSel[$];
  int          ackCyc[$];
  logic [3:0]  ackVal[$];
  int          rspCyc[$];
  logic [1:0]  rspId[$];
  logic [15:0] rspData[$];
  logic [15:0] expData[$];

  function automatic int rrPick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < 4; k++) begin
      int idx;
      idx = (ptr + k) % 4;
      if (mask[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic clearLogs();
    goCyc.delete(); goSel.delete(); ackCyc.delete(); ackVal.delete();
    rspCyc.delete(); rspId.delete(); rspData.delete(); expData.delete();
  endtask

  // One clock: log a handshake in the current cycle, then advance to the next
  // falling edge and run the tree model and requester behaviour.
  task automatic step();
    if (rsp_valid === 1'b1 && rsp_ready === 1'b1) begin
      rspCyc.push_back(cyc); rspId.push_back(rsp_id); rspData.push_back(rsp_data);
    end
    @(negedge clk);
    cyc++;
    strayReady = 1'b0;
    modelReady = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0 && !treeNever) begin
        modelReady  = 1'b1;
        tree_result = nextResult;
        expData.push_back(nextResult);
        nextResult  = 16'($urandom);
      end
    end
    if (tree_go === 1'b1) begin
      cd = treeLatency;
      if (randLatency) treeLatency = $urandom_range(1, 20);
      goCyc.push_back(cyc); goSel.push_back(tree_sel);
    end
    if (err_timeout === 1'b1 && errRise < 0) errRise = cyc;
    if (req_ack !== 4'b0000) begin
      ackCyc.push_back(cyc); ackVal.push_back(req_ack);
      if (dropMode == 1) req_valid &= ~req_ack;
      else if (dropMode == 2) req_valid = '0;
    end
    if (randReady) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic waitRsp(input int n);
    for (int k = 0; k < 300 && rspId.size() < n; k++) step();
  endtask

  task automatic waitIdle();
    for (int k = 0; k < 300 && busy !== 1'b0; k++) step();
    step();
    step();
  endtask

  task automatic applyStimulus(input logic [3:0] mask, input int latency);
    treeLatency = latency;
    req_valid   = mask;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    checks += 8;
    if (tree_go !== 1'b0)    begin errors++; $display("[TB] FAIL reset_tree_go: got %b expected 0", tree_go); end
    if (req_ack !== 4'b0)    begin errors++; $display("[TB] FAIL reset_req_ack: got %b expected 0000", req_ack); end
    if (rsp_valid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", err_timeout); end
    if (tree_sel !== 2'd0)   begin errors++; $display("[TB] FAIL reset_tree_sel: got %0d expected 0", tree_sel); end
    if (rsp_id !== 2'd0)     begin errors++; $display("[TB] FAIL reset_rsp_id: got %0d expected 0", rsp_id); end
    if (rsp_data !== 16'd0)  begin errors++; $display("[TB] FAIL reset_rsp_data: got %h expected 0000", rsp_data); end
    rst = 1'b0;
    step();
    expPtr = 0;
  endtask

  task automatic test_single();
    int c0;
    clearLogs();
    treeNever = 0; randLatency = 0; dropMode = 1; rsp_ready = 1'b1;
    nextResult = 16'h1234;
    c0 = cyc;
    applyStimulus(4'b0100, 11);
    waitRsp(1);
    waitIdle();
    checks += 7;
    if (goCyc.size() != 1 || goSel[0] !== 2'd2) begin errors++; $display("[TB] FAIL single_go: got %0d pulses sel %0d expected 1 pulse sel 2", goCyc.size(), goSel.size() > 0 ? goSel[0] : 2'd0); end
    if (goCyc.size() < 1 || goCyc[0] != c0 + 1) begin errors++; $display("[TB] FAIL single_go_cycle: got %0d expected %0d", goCyc.size() > 0 ? goCyc[0] : -1, c0 + 1); end
    if (rspId.size() != 1 || rspId[0] !== 2'd2) begin errors++; $display("[TB] FAIL single_rsp_id: got %0d responses id %0d expected 1 id 2", rspId.size(), rspId.size() > 0 ? rspId[0] : 2'd0); end
    if (rspData.size() < 1 || rspData[0] !== 16'h1234) begin errors++; $display("[TB] FAIL single_rsp_data: got %h expected 1234", rspData.size() > 0 ? rspData[0] : 16'h0); end
    if (ackVal.size() != 1 || ackVal[0] !== 4'b0100) begin errors++; $display("[TB] FAIL single_ack: got %0d pulses first %b expected 1 pulse 0100", ackVal.size(), ackVal.size() > 0 ? ackVal[0] : 4'b0); end
    if (ackCyc.size() < 1 || goCyc.size() < 1 || ackCyc[0] != goCyc[0] + 12) begin errors++; $display("[TB] FAIL single_ack_cycle: got %0d expected %0d", ackCyc.size() > 0 ? ackCyc[0] : -1, goCyc.size() > 0 ? goCyc[0] + 12 : -1); end
    if (rspCyc.size() < 1 || goCyc.size() < 1 || rspCyc[0] != goCyc[0] + 12) begin errors++; $display("[TB] FAIL single_rsp_cycle: got %0d expected %0d", rspCyc.size() > 0 ? rspCyc[0] : -1, goCyc.size() > 0 ? goCyc[0] + 12 : -1); end
    expPtr = 3;
  endtask

  task automatic test_round_robin();
    int n;
    int expId;
    int startPtr;
    clearLogs();
    startPtr = expPtr;
    dropMode = 0; randLatency = 1;
    applyStimulus(4'b1111, 5);
    for (int k = 0; k < 500 && rspId.size() < 5; k++) step();
    req_valid = '0;
    waitIdle();
    randLatency = 0;
    n = rspId.size();
    checks += 3;
    if (n < 5) begin errors++; $display("[TB] FAIL rr_count: got %0d responses expected at least 5", n); end
    if (goCyc.size() != n || ackVal.size() != n) begin errors++; $display("[TB] FAIL rr_pulses: got %0d go %0d ack expected %0d each", goCyc.size(), ackVal.size(), n); end
    if (expData.size() != n) begin errors++; $display("[TB] FAIL rr_tree_ops: got %0d completions expected %0d", expData.size(), n); end
    for (int i = 0; i < n && i < goSel.size() && i < ackVal.size() && i < expData.size(); i++) begin
      expId = (startPtr + i) % 4;
      checks += 3;
      if (rspId[i] !== 2'(expId) || goSel[i] !== 2'(expId)) begin errors++; $display("[TB] FAIL rr_id%0d: got rsp %0d sel %0d expected %0d", i, rspId[i], goSel[i], expId); end
      if (rspData[i] !== expData[i]) begin errors++; $display("[TB] FAIL rr_data%0d: got %h expected %h", i, rspData[i], expData[i]); end
      if (ackVal[i] !== 4'(1 << expId)) begin errors++; $display("[TB] FAIL rr_ack%0d: got %b expected %b", i, ackVal[i], 4'(1 << expId)); end
    end
    expPtr = (startPtr + n) % 4;
  endtask

  task automatic test_backpressure();
    int m;
    clearLogs();
    dropMode = 1; rsp_ready = 1'b0;
    applyStimulus(4'b0001, 3);
    for (int k = 0; k < 100 && rsp_valid !== 1'b1; k++) step();
    req_valid |= 4'b0010;
    checks++;
    if (rsp_valid !== 1'b1) begin errors++; $display("[TB] FAIL bp_valid_rise: got %b expected 1", rsp_valid); end
    for (int k = 0; k < 5; k++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || expData.size() < 1 || rsp_data !== expData[0])
        begin errors++; $display("[TB] FAIL bp_hold%0d: got valid %b id %0d data %h expected 1 0 %h", k, rsp_valid, rsp_id, rsp_data, expData.size() > 0 ? expData[0] : 16'h0); end
    end
    checks++;
    if (goCyc.size() != 1) begin errors++; $display("[TB] FAIL bp_no_go: got %0d launches expected 1", goCyc.size()); end
    m = cyc;
    rsp_ready = 1'b1;
    for (int k = 0; k < 20 && goCyc.size() < 2; k++) step();
    checks += 2;
    if (goCyc.size() < 2 || goCyc[1] != m + 2) begin errors++; $display("[TB] FAIL bp_next_go: got cycle %0d expected %0d", goCyc.size() > 1 ? goCyc[1] : -1, m + 2); end
    if (goSel.size() < 2 || goSel[1] !== 2'd1) begin errors++; $display("[TB] FAIL bp_next_sel: got %0d expected 1", goSel.size() > 1 ? goSel[1] : 2'd0); end
    waitRsp(2);
    waitIdle();
    checks++;
    if (rspId.size() != 2 || rspId[0] !== 2'd0 || rspId[1] !== 2'd1) begin errors++; $display("[TB] FAIL bp_ids: got %0d responses expected ids 0,1", rspId.size()); end
    expPtr = 2;
  endtask

  task automatic test_stray();
    clearLogs();
    req_valid = '0; dropMode = 1;
    strayReady = 1'b1;
    for (int k = 0; k < 6; k++) step();
    checks += 2;
    if (rspId.size() != 0 || ackVal.size() != 0) begin errors++; $display("[TB] FAIL stray_rsp: got %0d responses %0d acks expected 0", rspId.size(), ackVal.size()); end
    if (goCyc.size() != 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL stray_go: got %0d launches busy %b expected 0", goCyc.size(), busy); end
    applyStimulus(4'b0100, 6);
    for (int k = 0; k < 20 && goCyc.size() < 1; k++) step();
    req_valid = '0;
    waitRsp(1);
    waitIdle();
    checks += 2;
    if (rspId.size() != 1 || rspId[0] !== 2'd2 || expData.size() < 1 || rspData[0] !== expData[0]) begin errors++; $display("[TB] FAIL drop_rsp: got %0d responses id %0d expected 1 id 2", rspId.size(), rspId.size() > 0 ? rspId[0] : 2'd0); end
    if (ackVal.size() != 1 || ackVal[0] !== 4'b0100) begin errors++; $display("[TB] FAIL drop_ack: got %0d acks expected 1 of 0100", ackVal.size()); end
    expPtr = 3;
  endtask

  task automatic test_timeout();
    clearLogs();
    treeNever = 1; dropMode = 1; rsp_ready = 1'b1; errRise = -1;
    applyStimulus(4'b1000, 5);
    waitRsp(1);
    waitIdle();
    checks += 4;
    if (rspId.size() != 1 || rspId[0] !== 2'd3 || rspData[0] !== 16'h0) begin errors++; $display("[TB] FAIL to_rsp: got %0d responses id %0d data %h expected id 3 data 0000", rspId.size(), rspId.size() > 0 ? rspId[0] : 2'd0, rspData.size() > 0 ? rspData[0] : 16'h0); end
    if (ackVal.size() != 1 || ackVal[0] !== 4'b1000) begin errors++; $display("[TB] FAIL to_ack: got %0d acks expected 1 of 1000", ackVal.size()); end
    if (goCyc.size() < 1 || ackCyc.size() < 1 || ackCyc[0] != goCyc[0] + TIMEOUT + 1) begin errors++; $display("[TB] FAIL to_ack_cycle: got %0d expected %0d", ackCyc.size() > 0 ? ackCyc[0] : -1, goCyc.size() > 0 ? goCyc[0] + TIMEOUT + 1 : -1); end
    if (goCyc.size() < 1 || errRise != goCyc[0] + TIMEOUT + 1) begin errors++; $display("[TB] FAIL to_err_rise: got %0d expected %0d", errRise, goCyc.size() > 0 ? goCyc[0] + TIMEOUT + 1 : -1); end
    treeNever = 0;
    applyStimulus(4'b0001, 5);
    waitRsp(2);
    waitIdle();
    checks += 2;
    if (err_timeout !== 1'b1) begin errors++; $display("[TB] FAIL to_sticky: got %b expected 1", err_timeout); end
    if (rspData.size() != 2 || expData.size() < 1 || rspData[1] !== expData[0]) begin errors++; $display("[TB] FAIL to_after_data: got %0d responses expected 2 with tree sum", rspData.size()); end
    expPtr = 1;
  endtask

  task automatic test_reset_in_wait();
    clearLogs();
    dropMode = 1; treeNever = 0;
    applyStimulus(4'b0010, 4);
    waitRsp(1);
    waitIdle();
    clearLogs();
    treeNever = 1;
    applyStimulus(4'b1000, 4);
    for (int k = 0; k < 20 && goCyc.size() < 1; k++) step();
    step(); step();
    rst = 1'b1; req_valid = '0;
    step();
    rst = 1'b0; cd = 0; strayReady = 1'b1;
    checks += 6;
    if (busy !== 1'b0 || rsp_valid !== 1'b0) begin errors++; $display("[TB] FAIL rw_state: got busy %b valid %b expected 0 0", busy, rsp_valid); end
    if (err_timeout !== 1'b0) begin errors++; $display("[TB] FAIL rw_err: got %b expected 0", err_timeout); end
    if (tree_go !== 1'b0 || req_ack !== 4'b0) begin errors++; $display("[TB] FAIL rw_pulses: got go %b ack %b expected 0", tree_go, req_ack); end
    if (tree_sel !== 2'd0 || rsp_id !== 2'd0) begin errors++; $display("[TB] FAIL rw_ids: got sel %0d id %0d expected 0 0", tree_sel, rsp_id); end
    if (rsp_data !== 16'h0) begin errors++; $display("[TB] FAIL rw_data: got %h expected 0000", rsp_data); end
    for (int k = 0; k < 6; k++) step();
    if (rspId.size() != 0 || ackVal.size() != 0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL rw_no_rsp: got %0d responses %0d acks busy %b expected none", rspId.size(), ackVal.size(), busy); end
    expPtr = 0;
    treeNever = 0;
    applyStimulus(4'b0110, 4);
    waitRsp(1);
    waitIdle();
    checks++;
    if (rspId.size() != 1 || rspId[0] !== 2'(rrPick(4'b0110, expPtr))) begin errors++; $display("[TB] FAIL rw_regrant: got %0d responses id %0d expected id %0d", rspId.size(), rspId.size() > 0 ? rspId[0] : 2'd0, rrPick(4'b0110, expPtr)); end
    expPtr = 2;
  endtask

  task automatic test_random();
    logic [3:0] mask;
    int expId;
    dropMode = 2; randReady = 1;
    for (int op = 0; op < 12; op++) begin
      clearLogs();
      mask = 4'($urandom_range(1, 15));
      expId = rrPick(mask, expPtr);
      applyStimulus(mask, $urandom_range(1, 20));
      waitRsp(1);
      waitIdle();
      checks += 3;
      if (rspId.size() != 1 || rspId[0] !== 2'(expId)) begin errors++; $display("[TB] FAIL rand%0d_id: mask %b got %0d responses id %0d expected id %0d", op, mask, rspId.size(), rspId.size() > 0 ? rspId[0] : 2'd0, expId); end
      if (rspData.size() < 1 || expData.size() < 1 || rspData[0] !== expData[0]) begin errors++; $display("[TB] FAIL rand%0d_data: got %h expected %h", op, rspData.size() > 0 ? rspData[0] : 16'h0, expData.size() > 0 ? expData[0] : 16'h0); end
      if (ackVal.size() != 1 || ackVal[0] !== 4'(1 << expId)) begin errors++; $display("[TB] FAIL rand%0d_ack: got %0d acks first %b expected %b", op, ackVal.size(), ackVal.size() > 0 ? ackVal[0] : 4'b0, 4'(1 << expId)); end
      expPtr = (expId + 1) % 4;
    end
    randReady = 0; rsp_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_stray();
    test_timeout();
    test_reset_in_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
